// File: rtl/xphm_mem_banked.sv
// Banked XPHM word store: NUM_BANKS simple-dual-port banks with optional post-reset zero
// sweep, read-valid tracking and write-first forwarding for same-cycle read/write collisions.

module sdp_bram #(
  parameter int unsigned DW       = 64,
  parameter int unsigned RW       = 10,
  parameter int unsigned NUM_PIPE = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int unsigned ROWS = 1 << RW;

  logic [DW-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read latency equals NUM_PIPE; zero means an asynchronous read into the caller's register.
  if (NUM_PIPE == 0) begin : g_async
    assign rdata = mem[raddr];
  end else begin : g_sync
    logic [DW-1:0] pipe [NUM_PIPE];

    always_ff @(posedge clk) begin
      pipe[0] <= mem[raddr];
      for (int i = 1; i < NUM_PIPE; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[NUM_PIPE-1];
  end
endmodule

module xphm_mem_banked #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned NUM_PIPE   = 2,
  parameter int unsigned INTERLEAVE = 1,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     ready,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     rd_vld,
  output logic [DATA_WIDTH-1:0]    dout,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    din
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned BD = DEPTH / NUM_BANKS;
  localparam int unsigned RW = AW - BW;
  localparam int unsigned SW = (BW > 0) ? BW : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? S_INIT : S_RUN;

  state_t        state, state_d;
  logic [RW-1:0] cnt, cnt_d;
  logic          init_we;

  logic [SW-1:0] rd_bank, wr_bank;
  logic [RW-1:0] rd_row, wr_row;
  logic          rd_acc, wr_acc;

  // Address split into bank select and row.
  if (BW == 0) begin : g_single
    assign rd_bank = '0;
    assign wr_bank = '0;
    assign rd_row  = rd_addr;
    assign wr_row  = wr_addr;
  end else if (INTERLEAVE != 0) begin : g_interleave
    assign rd_bank = rd_addr[BW-1:0];
    assign wr_bank = wr_addr[BW-1:0];
    assign rd_row  = rd_addr[AW-1:BW];
    assign wr_row  = wr_addr[AW-1:BW];
  end else begin : g_contig
    assign rd_bank = rd_addr[AW-1:RW];
    assign wr_bank = wr_addr[AW-1:RW];
    assign rd_row  = rd_addr[RW-1:0];
    assign wr_row  = wr_addr[RW-1:0];
  end

  assign rd_acc = rd_en & ready;
  assign wr_acc = wr_en & ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RST_STATE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ready <= (state_d == S_RUN);
    end
  end

  // Zero sweep writes one row of every bank per cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    init_we = 1'b0;
    case (state)
      S_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt + RW'(1);
        if (cnt == RW'(BD - 1)) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  logic [DW-1:0] bank_rdata [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic          we;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;

    always_comb begin
      we    = init_we | (wr_acc & (wr_bank == SW'(b)));
      waddr = init_we ? cnt : wr_row;
      wdata = init_we ? '0 : din;
    end

    sdp_bram #(
      .DW       (DW),
      .RW       (RW),
      .NUM_PIPE (NUM_PIPE)
    ) u_bram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rd_row),
      .rdata (bank_rdata[b])
    );
  end

  logic          req_vld, req_fwd;
  logic [SW-1:0] req_bank;
  logic [DW-1:0] req_fdata;

  assign req_vld   = rd_acc;
  assign req_fwd   = rd_acc & wr_acc & (rd_addr == wr_addr);
  assign req_bank  = rd_bank;
  assign req_fdata = din;

  logic          m_vld, m_fwd;
  logic [SW-1:0] m_bank;
  logic [DW-1:0] m_fdata;

  // Side-band travels alongside the bank read so it arrives with the bank data.
  if (NUM_PIPE == 0) begin : g_nopipe
    assign m_vld   = req_vld;
    assign m_fwd   = req_fwd;
    assign m_bank  = req_bank;
    assign m_fdata = req_fdata;
  end else begin : g_pipe
    logic          p_vld   [NUM_PIPE];
    logic          p_fwd   [NUM_PIPE];
    logic [SW-1:0] p_bank  [NUM_PIPE];
    logic [DW-1:0] p_fdata [NUM_PIPE];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < NUM_PIPE; i++) begin
          p_vld[i]   <= 1'b0;
          p_fwd[i]   <= 1'b0;
          p_bank[i]  <= '0;
          p_fdata[i] <= '0;
        end
      end else begin
        p_vld[0]   <= req_vld;
        p_fwd[0]   <= req_fwd;
        p_bank[0]  <= req_bank;
        p_fdata[0] <= req_fdata;
        for (int i = 1; i < NUM_PIPE; i++) begin
          p_vld[i]   <= p_vld[i-1];
          p_fwd[i]   <= p_fwd[i-1];
          p_bank[i]  <= p_bank[i-1];
          p_fdata[i] <= p_fdata[i-1];
        end
      end
    end

    assign m_vld   = p_vld[NUM_PIPE-1];
    assign m_fwd   = p_fwd[NUM_PIPE-1];
    assign m_bank  = p_bank[NUM_PIPE-1];
    assign m_fdata = p_fdata[NUM_PIPE-1];
  end

  logic [DW-1:0] sel_rdata;

  always_comb begin
    sel_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (m_bank == SW'(b)) sel_rdata = bank_rdata[b];
    end
  end

  // Output register closes the read latency; dout holds between results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld <= 1'b0;
      dout   <= '0;
    end else begin
      rd_vld <= m_vld;
      if (m_vld) dout <= m_fwd ? m_fdata : sel_rdata;
    end
  end
endmodule

// File: tb/tb_xphm_mem_banked.sv
// Directed bench for xphm_mem_banked: three builds (4-bank interleaved RL=3,
// 1-bank RL=1, 4-bank contiguous RL=2) share one stimulus stream.

module tb_xphm_mem_banked;
  localparam int unsigned NV = 28;

  logic        clk;
  logic        rstn;
  logic        rd_en, wr_en;
  logic [11:0] rd_addr, wr_addr;
  logic [63:0] din;

  logic        ready0, ready1, ready2;
  logic        vld0, vld1, vld2;
  logic [63:0] dout0, dout1, dout2;

  int checks = 0;
  int errs   = 0;

  xphm_mem_banked #(.DATA_WIDTH(64), .DEPTH(4096), .NUM_BANKS(4), .NUM_PIPE(2),
                    .INTERLEAVE(1), .INIT_ZERO(1)) dut (
    .clk(clk), .rstn(rstn), .ready(ready0), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_vld(vld0), .dout(dout0), .wr_en(wr_en), .wr_addr(wr_addr), .din(din));

  xphm_mem_banked #(.DATA_WIDTH(64), .DEPTH(4096), .NUM_BANKS(1), .NUM_PIPE(0),
                    .INTERLEAVE(1), .INIT_ZERO(1)) dut1 (
    .clk(clk), .rstn(rstn), .ready(ready1), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_vld(vld1), .dout(dout1), .wr_en(wr_en), .wr_addr(wr_addr), .din(din));

  xphm_mem_banked #(.DATA_WIDTH(64), .DEPTH(4096), .NUM_BANKS(4), .NUM_PIPE(1),
                    .INTERLEAVE(0), .INIT_ZERO(1)) dut2 (
    .clk(clk), .rstn(rstn), .ready(ready2), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_vld(vld2), .dout(dout2), .wr_en(wr_en), .wr_addr(wr_addr), .din(din));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [63:0] wd;
    logic        re;
    logic [11:0] ra;
    logic        ev;
    logic [63:0] ed;
  } vec_t;

  vec_t        vt [NV];
  logic [63:0] last_dout [3];

  function automatic vec_t mk(input logic we, input logic [11:0] wa, input logic [63:0] wd,
                              input logic re, input logic [11:0] ra, input logic [63:0] ed);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.re = re; v.ra = ra; v.ev = re; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [11:0] wa, input logic [63:0] wd,
                       input logic re, input logic [11:0] ra);
    wr_en = we; wr_addr = wa; din = wd; rd_en = re; rd_addr = ra;
  endtask

  // Compare one build's output against the vector issued RL cycles earlier.
  task automatic chk_out(input int inst, input int idx);
    logic        av, ev;
    logic [63:0] ad, ed;
    case (inst)
      0:       begin av = vld0; ad = dout0; end
      1:       begin av = vld1; ad = dout1; end
      default: begin av = vld2; ad = dout2; end
    endcase
    ev = 1'b0;
    ed = last_dout[inst];
    if (idx >= 0 && idx < int'(NV)) begin
      ev = vt[idx].ev;
      if (ev) ed = vt[idx].ed;
    end
    chk($sformatf("rd_vld inst%0d vec%0d", inst, idx), 64'(av), 64'(ev));
    chk($sformatf("dout inst%0d vec%0d", inst, idx), ad, ed);
    last_dout[inst] = ed;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vt[i] = mk(1'b1, 12'(i), 64'(i) * 64'h11, 1'b0, 12'h0, 64'h0);
    for (int i = 8; i < 16; i++) vt[i] = mk(1'b0, 12'h0, 64'h0, 1'b1, 12'(i - 8), 64'(i - 8) * 64'h11);
    vt[16] = mk(1'b1, 12'h020, 64'h1234, 1'b0, 12'h000, 64'h0);
    vt[17] = mk(1'b1, 12'h020, 64'hBEEF, 1'b1, 12'h020, 64'hBEEF);
    vt[18] = mk(1'b1, 12'h020, 64'h1234, 1'b0, 12'h000, 64'h0);
    vt[19] = mk(1'b0, 12'h000, 64'h0,    1'b1, 12'h020, 64'h1234);
    vt[20] = mk(1'b1, 12'h020, 64'hCAFE, 1'b0, 12'h000, 64'h0);
    vt[21] = mk(1'b0, 12'h000, 64'h0,    1'b1, 12'h020, 64'hCAFE);
    vt[22] = mk(1'b0, 12'h000, 64'h0,    1'b1, 12'h010, 64'h0);
    vt[23] = mk(1'b1, 12'h008, 64'h5555, 1'b1, 12'h004, 64'h44);
    vt[24] = mk(1'b0, 12'h000, 64'h0,    1'b1, 12'h008, 64'h5555);
    vt[25] = mk(1'b1, 12'h400, 64'hABCD, 1'b0, 12'h000, 64'h0);
    vt[26] = mk(1'b1, 12'h401, 64'h77,   1'b1, 12'h400, 64'hABCD);
    vt[27] = mk(1'b0, 12'h000, 64'h0,    1'b1, 12'hC01, 64'h0);
    for (int i = 0; i < 3; i++) last_dout[i] = 64'h0;

    rstn = 1'b0;
    drive(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
    repeat (3) @(negedge clk);
    chk("reset ready", {ready2, ready1, ready0}, 64'h0);
    chk("reset rd_vld", {vld2, vld1, vld0}, 64'h0);
    chk("reset dout0", dout0, 64'h0);
    chk("reset dout1", dout1, 64'h0);
    chk("reset dout2", dout2, 64'h0);

    @(posedge clk); #1 rstn = 1'b1;

    // Init sweep: a write and two reads during INIT must be ignored.
    for (int n = 1; n <= 4096; n++) begin
      @(posedge clk); #1;
      drive(n == 5, 12'h010, 64'hAA, (n == 6) || (n == 7), 12'h010);
      @(negedge clk);
      if (vld0 || vld1 || vld2) chk($sformatf("init rd_vld cyc%0d", n), {vld2, vld1, vld0}, 64'h0);
      if (n == 1023) chk("ready before sweep end", {ready2, ready1, ready0}, 64'h0);
      if (n == 1024) chk("ready at sweep end", {ready2, ready1, ready0}, 64'b101);
      if (n == 4095) chk("ready1 before sweep end", 64'(ready1), 64'h0);
      if (n == 4096) chk("ready all", {ready2, ready1, ready0}, 64'b111);
    end
    chk("dout held through init", dout0 | dout1 | dout2, 64'h0);

    for (int c = 0; c < int'(NV) + 4; c++) begin
      @(posedge clk); #1;
      if (c < int'(NV)) drive(vt[c].we, vt[c].wa, vt[c].wd, vt[c].re, vt[c].ra);
      else              drive(1'b0, 12'h0, 64'h0, 1'b0, 12'h0);
      @(negedge clk);
      chk_out(0, c - 3);
      chk_out(1, c - 1);
      chk_out(2, c - 2);
    end

    // Two reads in flight, then reset: nothing may emerge.
    @(posedge clk); #1 drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h001);
    @(posedge clk); #1 drive(1'b0, 12'h0, 64'h0, 1'b1, 12'h002);
    @(posedge clk); #1 drive(1'b0, 12'h0, 64'h0, 1'b0, 12'h000);
    rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midreset rd_vld cyc%0d", k), {vld2, vld0}, 64'h0);
      chk($sformatf("midreset ready cyc%0d", k), {ready2, ready1, ready0}, 64'h0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("reinit ready", {ready2, ready1, ready0}, 64'h0);
    chk("reinit rd_vld", {vld2, vld1, vld0}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
